// File: rtl/nco_lockin_accum_pkg.sv
// rtl/nco_lockin_accum_pkg.sv - shared widths, state encoding and saturation limits for the lock-in arm
package nco_lockin_pkg;

   localparam int DEFAULT_SIN_W  = 13;
   localparam int DEFAULT_ADC_W  = 14;
   localparam int DEFAULT_ACC_W  = 40;
   localparam int DEFAULT_LEN_W  = 16;
   localparam int DEFAULT_PROD_W = DEFAULT_SIN_W + DEFAULT_ADC_W;

   localparam logic signed [DEFAULT_ACC_W-1:0] ACC_MAX = {1'b0, {(DEFAULT_ACC_W-1){1'b1}}};
   localparam logic signed [DEFAULT_ACC_W-1:0] ACC_MIN = {1'b1, {(DEFAULT_ACC_W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/nco_lockin_accum_if.sv
// rtl/nco_lockin_accum_if.sv - sample, control and result signals of one lock-in arm
interface nco_lockin_accum_if
   import nco_lockin_pkg::*;
#(
   parameter int SIN_W = DEFAULT_SIN_W,
   parameter int ADC_W = DEFAULT_ADC_W,
   parameter int ACC_W = DEFAULT_ACC_W,
   parameter int LEN_W = DEFAULT_LEN_W
) ();

   logic                     start;
   logic [LEN_W-1:0]         integ_len;
   logic                     sin_valid;
   logic signed [SIN_W-1:0]  sin_val;
   logic signed [ADC_W-1:0]  adc_data;
   logic                     busy;
   logic                     res_valid;
   logic signed [ACC_W-1:0]  res_data;
   logic                     overflow;

   modport master (
      output start, integ_len, sin_valid, sin_val, adc_data,
      input  busy, res_valid, res_data, overflow
   );

   modport slave (
      input  start, integ_len, sin_valid, sin_val, adc_data,
      output busy, res_valid, res_data, overflow
   );

endinterface

// File: rtl/nco_lockin_accum_mac_sat.sv
// rtl/nco_lockin_accum_mac_sat.sv - registered signed product feeding a saturating accumulator with sticky overflow
module lockin_mac_sat #(
   parameter int SIN_W = 13,
   parameter int ADC_W = 14,
   parameter int ACC_W = 40
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    clken,
   input  logic                    clear,
   input  logic                    in_vld,
   input  logic signed [SIN_W-1:0] a,
   input  logic signed [ADC_W-1:0] b,
   output logic signed [ACC_W-1:0] acc,
   output logic                    ovf
);

   localparam int PROD_W = SIN_W + ADC_W;
   localparam int SUM_W  = ACC_W + 1;

   logic signed [PROD_W-1:0] prod_q;
   logic                     prod_vld;
   logic [SUM_W-1:0]         sum;
   logic                     sat_hi;
   logic                     sat_lo;

   // One guard bit: disagreement between the top two sum bits means the true sum left the ACC_W range
   always_comb begin
      sum    = {acc[ACC_W-1], acc} + SUM_W'(prod_q);
      sat_hi = !sum[ACC_W] &&  sum[ACC_W-1];
      sat_lo =  sum[ACC_W] && !sum[ACC_W-1];
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         prod_q   <= '0;
         prod_vld <= 1'b0;
         acc      <= '0;
         ovf      <= 1'b0;
      end else if (clken) begin
         if (clear) begin
            prod_q   <= '0;
            prod_vld <= 1'b0;
            acc      <= '0;
            ovf      <= 1'b0;
         end else begin
            prod_vld <= in_vld;
            if (in_vld)
               prod_q <= PROD_W'(a) * PROD_W'(b);
            if (prod_vld) begin
               if (sat_hi)
                  acc <= {1'b0, {(ACC_W-1){1'b1}}};
               else if (sat_lo)
                  acc <= {1'b1, {(ACC_W-1){1'b0}}};
               else
                  acc <= sum[ACC_W-1:0];
               ovf <= ovf | sat_hi | sat_lo;
            end
         end
      end
   end

endmodule

// File: rtl/nco_lockin_accum.sv
// rtl/nco_lockin_accum.sv - one quadrature arm of the lock-in demodulator: integrates NCO x ADC over integ_len samples
module nco_lockin_accum
   import nco_lockin_pkg::*;
#(
   parameter int SIN_W = DEFAULT_SIN_W,
   parameter int ADC_W = DEFAULT_ADC_W,
   parameter int ACC_W = DEFAULT_ACC_W,
   parameter int LEN_W = DEFAULT_LEN_W
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               clken,
   nco_lockin_accum_if.slave  bus
);

   state_t                   state;
   state_t                   state_next;
   logic [LEN_W-1:0]         len_q;
   logic [LEN_W-1:0]         count_q;
   logic                     mac_clear;
   logic                     mac_in_vld;
   logic signed [ACC_W-1:0]  acc;
   logic                     ovf;
   logic                     res_valid_q;
   logic signed [ACC_W-1:0]  res_data_q;
   logic                     overflow_q;

   always_ff @(posedge clk) begin
      if (!reset_n)
         state <= IDLE;
      else if (clken)
         state <= state_next;
   end

   // FLUSH lasts exactly one edge: the last product is always pending when RUN exits
   always_comb begin
      state_next = state;
      mac_clear  = 1'b0;
      mac_in_vld = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start && bus.integ_len != '0) begin
               mac_clear  = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (bus.sin_valid) begin
               mac_in_vld = 1'b1;
               if (count_q + LEN_W'(1) == len_q)
                  state_next = FLUSH;
            end
         end
         FLUSH:   state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         len_q       <= '0;
         count_q     <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         overflow_q  <= 1'b0;
      end else if (clken) begin
         if (mac_clear) begin
            len_q   <= bus.integ_len;
            count_q <= '0;
         end else if (mac_in_vld) begin
            count_q <= count_q + LEN_W'(1);
         end
         res_valid_q <= (state == DONE);
         if (state == DONE) begin
            res_data_q <= acc;
            overflow_q <= ovf;
         end
      end
   end

   lockin_mac_sat #(
      .SIN_W (SIN_W),
      .ADC_W (ADC_W),
      .ACC_W (ACC_W)
   ) u_mac (
      .clk     (clk),
      .reset_n (reset_n),
      .clken   (clken),
      .clear   (mac_clear),
      .in_vld  (mac_in_vld),
      .a       (bus.sin_val),
      .b       (bus.adc_data),
      .acc     (acc),
      .ovf     (ovf)
   );

   assign bus.busy      = (state != IDLE);
   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;
   assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_nco_lockin_accum.sv
// tb/tb_nco_lockin_accum.sv - directed bench for nco_lockin_accum at 40-bit and 28-bit accumulator widths
module tb_nco_lockin_accum;

   logic               clk;
   logic               reset_n;
   logic               clken;
   logic               start;
   logic [15:0]        integ_len;
   logic               sin_valid;
   logic signed [12:0] sin_val;
   logic signed [13:0] adc_data;

   int n_vec;
   int n_err;

   nco_lockin_accum_if #(.SIN_W(13), .ADC_W(14), .ACC_W(40), .LEN_W(16)) ifa ();
   nco_lockin_accum_if #(.SIN_W(13), .ADC_W(14), .ACC_W(28), .LEN_W(16)) ifb ();

   assign ifa.start     = start;
   assign ifa.integ_len = integ_len;
   assign ifa.sin_valid = sin_valid;
   assign ifa.sin_val   = sin_val;
   assign ifa.adc_data  = adc_data;
   assign ifb.start     = start;
   assign ifb.integ_len = integ_len;
   assign ifb.sin_valid = sin_valid;
   assign ifb.sin_val   = sin_val;
   assign ifb.adc_data  = adc_data;

   nco_lockin_accum #(.SIN_W(13), .ADC_W(14), .ACC_W(40), .LEN_W(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .clken   (clken),
      .bus     (ifa)
   );

   nco_lockin_accum #(.SIN_W(13), .ADC_W(14), .ACC_W(28), .LEN_W(16)) dut28 (
      .clk     (clk),
      .reset_n (reset_n),
      .clken   (clken),
      .bus     (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [15:0] len);
      start     = 1'b1;
      integ_len = len;
      tick();
      start     = 1'b0;
   endtask

   task automatic feed(input logic signed [12:0] s, input logic signed [13:0] a, input int n);
      sin_valid = 1'b1;
      sin_val   = s;
      adc_data  = a;
      for (int i = 0; i < n; i++) tick();
      sin_valid = 1'b0;
   endtask

   task automatic wait_res(input int max, output int cyc);
      cyc = -1;
      for (int i = 1; i <= max; i++) begin
         tick();
         if (ifa.res_valid && cyc < 0) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      clken   = 1'b0;
      tick();
      tick();
      n_vec++;
      if (ifa.busy !== 1'b0 || ifa.res_valid !== 1'b0 || ifa.res_data !== 40'sd0 || ifa.overflow !== 1'b0) begin
         n_err++;
         $display("FAIL reset40: busy=%b rv=%b data=%0d ovf=%b required 0 0 0 0", ifa.busy, ifa.res_valid, ifa.res_data, ifa.overflow);
      end
      n_vec++;
      if (ifb.busy !== 1'b0 || ifb.res_valid !== 1'b0 || ifb.res_data !== 28'sd0 || ifb.overflow !== 1'b0) begin
         n_err++;
         $display("FAIL reset28: busy=%b rv=%b data=%0d ovf=%b required 0 0 0 0", ifb.busy, ifb.res_valid, ifb.res_data, ifb.overflow);
      end
      clken   = 1'b1;
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int first;
      int cnt;
      logic busy_ok;
      first   = -1;
      cnt     = 0;
      busy_ok = 1'b1;
      sin_valid = 1'b1;
      sin_val   = 13'sd1000;
      adc_data  = 14'sd2;
      pulse_start(16'd4);
      n_vec++;
      if (ifa.busy !== 1'b1) begin
         n_err++;
         $display("FAIL basic_busy_start: got %b required 1", ifa.busy);
      end
      for (int k = 1; k <= 9; k++) begin
         tick();
         if (ifa.res_valid === 1'b1) begin
            cnt++;
            if (first < 0) first = k;
         end
         if (k < 6 && ifa.busy !== 1'b1) busy_ok = 1'b0;
         if (k == 6 && ifa.busy !== 1'b0) busy_ok = 1'b0;
      end
      sin_valid = 1'b0;
      n_vec++;
      if (first != 6 || cnt != 1) begin
         n_err++;
         $display("FAIL basic_timing: first=%0d count=%0d required 6 1", first, cnt);
      end
      n_vec++;
      if (ifa.res_data !== 40'sd8000 || ifa.overflow !== 1'b0) begin
         n_err++;
         $display("FAIL basic_data: data=%0d ovf=%b required 8000 0", ifa.res_data, ifa.overflow);
      end
      n_vec++;
      if (busy_ok !== 1'b1) begin
         n_err++;
         $display("FAIL basic_busy_window: got %b required 1", busy_ok);
      end
   endtask

   task automatic test_extremes();
      int cyc;
      pulse_start(16'd1);
      feed(-13'sd4096, -14'sd8192, 1);
      wait_res(8, cyc);
      n_vec++;
      if (cyc != 2 || ifa.res_data !== 40'sd33554432 || ifa.overflow !== 1'b0) begin
         n_err++;
         $display("FAIL extreme_neg: cyc=%0d data=%0d ovf=%b required 2 33554432 0", cyc, ifa.res_data, ifa.overflow);
      end
      tick();
      pulse_start(16'd2);
      feed(13'sd4095, -14'sd1, 2);
      wait_res(8, cyc);
      n_vec++;
      if (cyc != 2 || ifa.res_data !== -40'sd8190) begin
         n_err++;
         $display("FAIL extreme_mixed: cyc=%0d data=%0d required 2 -8190", cyc, ifa.res_data);
      end
      tick();
   endtask

   task automatic test_gaps();
      int cyc;
      logic        vpat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [13:0] dpat [6] = '{14'd10, 14'd99, 14'd99, 14'd20, 14'd99, 14'd30};
      pulse_start(16'd3);
      sin_val = 13'sd3;
      for (int i = 0; i < 6; i++) begin
         sin_valid = vpat[i];
         adc_data  = dpat[i];
         tick();
      end
      sin_valid = 1'b0;
      wait_res(8, cyc);
      n_vec++;
      if (cyc != 2 || ifa.res_data !== 40'sd180) begin
         n_err++;
         $display("FAIL gaps: cyc=%0d data=%0d required 2 180", cyc, ifa.res_data);
      end
      tick();
   endtask

   task automatic test_saturation();
      int cyc;
      pulse_start(16'd4);
      feed(-13'sd4096, -14'sd8192, 4);
      wait_res(8, cyc);
      n_vec++;
      if (cyc != 2 || ifb.res_data !== 28'sd134217727 || ifb.overflow !== 1'b1) begin
         n_err++;
         $display("FAIL sat28: cyc=%0d data=%0d ovf=%b required 2 134217727 1", cyc, ifb.res_data, ifb.overflow);
      end
      n_vec++;
      if (ifa.res_data !== 40'sd134217728 || ifa.overflow !== 1'b0) begin
         n_err++;
         $display("FAIL nosat40: data=%0d ovf=%b required 134217728 0", ifa.res_data, ifa.overflow);
      end
      tick();
      pulse_start(16'd1);
      feed(13'sd1, 14'sd1, 1);
      wait_res(8, cyc);
      n_vec++;
      if (cyc != 2 || ifb.res_data !== 28'sd1 || ifb.overflow !== 1'b0) begin
         n_err++;
         $display("FAIL sat28_clear: cyc=%0d data=%0d ovf=%b required 2 1 0", cyc, ifb.res_data, ifb.overflow);
      end
      tick();
   endtask

   task automatic test_ignored_starts();
      int cyc;
      int cnt;
      pulse_start(16'd0);
      n_vec++;
      if (ifa.busy !== 1'b0) begin
         n_err++;
         $display("FAIL zero_len_busy: got %b required 0", ifa.busy);
      end
      wait_res(10, cyc);
      n_vec++;
      if (cyc != -1) begin
         n_err++;
         $display("FAIL zero_len_result: res_valid at %0d required none", cyc);
      end
      pulse_start(16'd3);
      sin_valid = 1'b1;
      sin_val   = 13'sd2;
      adc_data  = 14'sd3;
      tick();
      start     = 1'b1;
      integ_len = 16'd1;
      tick();
      start     = 1'b0;
      tick();
      sin_valid = 1'b0;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (ifa.res_valid === 1'b1) cnt++;
      end
      n_vec++;
      if (cnt != 1 || ifa.res_data !== 40'sd18) begin
         n_err++;
         $display("FAIL start_midrun: results=%0d data=%0d required 1 18", cnt, ifa.res_data);
      end
   endtask

   task automatic test_clken();
      int cyc;
      pulse_start(16'd2);
      feed(13'sd7, 14'sd8, 2);
      cyc = -1;
      for (int i = 1; i <= 14; i++) begin
         clken = (i <= 5) ? 1'b0 : 1'b1;
         tick();
         if (ifa.res_valid === 1'b1) begin
            cyc = i;
            break;
         end
      end
      clken = 1'b1;
      n_vec++;
      if (cyc != 7 || ifa.res_data !== 40'sd112) begin
         n_err++;
         $display("FAIL clken_stall: cyc=%0d data=%0d required 7 112", cyc, ifa.res_data);
      end
      clken = 1'b0;
      tick();
      tick();
      n_vec++;
      if (ifa.res_valid !== 1'b1) begin
         n_err++;
         $display("FAIL clken_hold_valid: got %b required 1", ifa.res_valid);
      end
      clken = 1'b1;
      tick();
      n_vec++;
      if (ifa.res_valid !== 1'b0 || ifa.res_data !== 40'sd112) begin
         n_err++;
         $display("FAIL clken_release: rv=%b data=%0d required 0 112", ifa.res_valid, ifa.res_data);
      end
   endtask

   task automatic test_reset_abort();
      int cyc;
      pulse_start(16'd4);
      feed(13'sd5, 14'sd5, 2);
      reset_n = 1'b0;
      tick();
      n_vec++;
      if (ifa.busy !== 1'b0 || ifa.res_valid !== 1'b0 || ifa.res_data !== 40'sd0) begin
         n_err++;
         $display("FAIL abort_reset: busy=%b rv=%b data=%0d required 0 0 0", ifa.busy, ifa.res_valid, ifa.res_data);
      end
      reset_n = 1'b1;
      wait_res(8, cyc);
      n_vec++;
      if (cyc != -1) begin
         n_err++;
         $display("FAIL abort_no_result: res_valid at %0d required none", cyc);
      end
      pulse_start(16'd2);
      feed(13'sd5, 14'sd5, 2);
      wait_res(8, cyc);
      n_vec++;
      if (cyc != 2 || ifa.res_data !== 40'sd50) begin
         n_err++;
         $display("FAIL abort_restart: cyc=%0d data=%0d required 2 50", cyc, ifa.res_data);
      end
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      reset_n   = 1'b0;
      clken     = 1'b0;
      start     = 1'b0;
      integ_len = 16'd0;
      sin_valid = 1'b0;
      sin_val   = 13'sd0;
      adc_data  = 14'sd0;
      test_reset();
      test_basic();
      test_extremes();
      test_gaps();
      test_saturation();
      test_ignored_starts();
      test_clken();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/nco_lockin_accum.md
Name: nco_lockin_accum

Overview:
Downstream consumer of the NCO_1MHz sine output. Multiplies each valid 13-bit signed NCO sample by the co-timed ADC sample and accumulates the products over a programmable number of samples. This forms one quadrature arm of the OCT lock-in demodulator. When an integration finishes, the block emits one saturated accumulator result with a single-cycle valid pulse.

Parameters:
SIN_W, 13, NCO sine width (two's complement)
ADC_W, 14, ADC sample width (two's complement)
ACC_W, 40, accumulator/result width (signed)
LEN_W, 16, integration length counter width

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
clken  in  1  global enable; low freezes all state, counters, pipeline and outputs
start  in  1  one-cycle pulse; begins integration
integ_len  in  LEN_W  number of valid samples to integrate; latched on accepted start
sin_valid  in  1  NCO out_valid
sin_val  in  SIN_W  NCO fsin_o, signed
adc_data  in  ADC_W  ADC sample aligned with sin_val, signed
busy  out  1  high from accepted start until res_valid
res_valid  out  1  one enabled-cycle pulse, result ready
res_data  out  ACC_W  signed integrated result; held until next result
overflow  out  1  saturation occurred during the integration; valid with res_valid, held with res_data

Behaviour:
- Reset, checked at posedge while reset_n=0 (regardless of clken): busy=0, res_valid=0, res_data=0, overflow=0, state=IDLE; counter, accumulator and product pipeline cleared. Reset mid-integration aborts it and produces no result.
- All non-reset updates occur only on edges where clken=1.
- States:
  - IDLE: on start=1 with integ_len!=0, latch integ_len, clear acc, count and ovf_sticky, go to RUN, busy=1. A start with integ_len=0 is ignored.
  - RUN: each edge with sin_valid=1 accepts a sample. It registers prod = sin_val*adc_data as signed, width SIN_W+ADC_W, and sets prod_vld=1. It also increments count. When the accepted sample makes count==len, go to FLUSH. Samples arriving in FLUSH/DONE are not accepted.
  - FLUSH: wait for the last product to be accumulated, then go to DONE.
  - DONE: res_data<=acc, overflow<=ovf_sticky, res_valid=1 for one enabled cycle, busy=0, then IDLE.
- Accumulate stage: on each edge with prod_vld=1, acc <= sat(acc + sext(prod)).
  - If the true sum exceeds +(2^(ACC_W-1)-1), clamp to that value and set ovf_sticky.
  - If it is below -2^(ACC_W-1), clamp to that value and set ovf_sticky.
  - Once saturated, later products still add normally from the clamped value.
- Latency: let E0 be the edge that accepts the last sample.
  - E1 adds it to acc.
  - E2 sets res_valid=1 and res_data.
  - E3 clears res_valid.
  - With clken=1 throughout, res_valid is therefore high in the 3rd cycle after the last sample.
- start while busy=1 is ignored, including in the DONE cycle. A start in the cycle after res_valid falls is accepted.
- sin_valid gaps are allowed; only cycles with sin_valid=1 count.
- adc_data is sampled only when sin_valid=1.
- clken=0 mid-run: nothing changes. A res_valid that is already high stays high until the next enabled edge.
- Extreme product -4096*-8192 = 2^25 fits in a 27-bit signed product with no internal overflow.

Decomposition:
- Package nco_lockin_pkg:
  - default widths SIN_W/ADC_W/ACC_W/LEN_W
  - PROD_W = SIN_W+ADC_W
  - state enum {IDLE, RUN, FLUSH, DONE}
  - ACC_MAX/ACC_MIN constants, functions of ACC_W
- One sub-module, lockin_mac_sat: product register plus saturating accumulator with sticky overflow. Inputs are clear, in_vld, a, b. Outputs are acc and ovf.
- The FSM, length counter and output registers stay in the top module.

Test Plan:
1. integ_len=4, sin_val=1000, adc_data=2, sin_valid=1 continuous, start pulse -> res_valid exactly once, 3 cycles after the 4th sample; res_data=8000; overflow=0; busy high from the start edge until res_valid.
2. integ_len=1, sin_val=-4096, adc_data=-8192 -> res_data=33554432. Then integ_len=2, sin_val=4095, adc_data=-1 -> res_data=-8190.
3. integ_len=3, sin_valid pattern 1,0,0,1,0,1 with adc_data 10/99/99/20/99/30 and sin_val=3 -> res_data=180; adc_data on invalid cycles is ignored.
4. ACC_W=28, integ_len=4, sin_val=-4096, adc_data=-8192 -> res_data=134217727 (2^27-1), overflow=1. A subsequent run with 1*1, integ_len=1 -> res_data=1, overflow=0.
5. Ignored starts and clken:
   - start with integ_len=0 -> busy stays 0 and no res_valid.
   - start pulsed mid-run -> exactly one result.
   - clken=0 for 5 cycles mid-run -> res_valid is delayed by exactly 5 cycles and res_data is unchanged.
6. reset_n=0 for 1 cycle after the 2nd of 4 samples -> busy=0, res_valid=0, res_data=0. A fresh start with integ_len=2, 5*5 -> res_data=50.
